// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the SPI RAM arbiter, its two requesters and the RAM.
// slave: the arbiter's view; master: the view of the requesters and RAM side.
interface spi_ram_arbiter_if;
  logic [9:0] req0_din;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_dout;
  logic       req0_dout_valid;
  logic [9:0] req1_din;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_dout;
  logic       req1_dout_valid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       grant;
  logic       busy;
  logic       err;

  modport slave (
    input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    output req0_ready, req0_dout, req0_dout_valid,
           req1_ready, req1_dout, req1_dout_valid,
           ram_din, ram_rx_valid, grant, busy, err
  );

  modport master (
    output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
    input  req0_ready, req0_dout, req0_dout_valid,
           req1_ready, req1_dout, req1_dout_valid,
           ram_din, ram_rx_valid, grant, busy, err
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one SPI RAM between two command-word requesters.
// The grant stays locked from the first word until the data word (01/11),
// so an address latched by one requester is never overwritten by the other.
module spi_ram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_WAIT_RD} state_t;

  state_t         r_state, w_next_state;
  logic           r_owner, w_next_owner;
  logic           r_last_owner;
  logic [CW-1:0]  r_cnt;
  logic [9:0]     r_ram_din;
  logic           r_ram_rx_valid;
  logic [7:0]     r_dout0, r_dout1;
  logic           r_dv0, r_dv1;
  logic           r_err;

  logic           w_hs;
  logic [9:0]     w_word;
  logic           w_timeout;
  logic           w_release;
  logic           w_err;
  logic           w_rd_ret;

  // Next state, handshake and release decisions
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_hs         = 1'b0;
    w_word       = r_owner ? bus.req1_din : bus.req0_din;
    w_timeout    = (r_cnt == CW'(TIMEOUT - 1));
    w_release    = 1'b0;
    w_err        = 1'b0;
    w_rd_ret     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_next_state = S_OWN;
          // On contention the requester that did not own last time wins
          w_next_owner = (bus.req0_valid && bus.req1_valid) ? ~r_last_owner
                                                             : bus.req1_valid;
        end
      end
      S_OWN: begin
        w_hs = r_owner ? bus.req1_valid : bus.req0_valid;
        if (w_hs) begin
          case (w_word[9:8])
            2'b01: begin
              w_next_state = S_IDLE;
              w_release    = 1'b1;
            end
            2'b11:   w_next_state = S_WAIT_RD;
            default: w_next_state = S_OWN;
          endcase
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_release    = 1'b1;
          w_err        = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (bus.ram_tx_valid) begin
          w_rd_ret     = 1'b1;
          w_next_state = S_IDLE;
          w_release    = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_release    = 1'b1;
          w_err        = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
    end
  end

  // Idle counter: restarts on every accepted word and whenever not locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_hs || (r_state == S_IDLE) || (w_next_state == S_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // RAM command path, read-data return, error pulse and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
      r_dout0        <= '0;
      r_dout1        <= '0;
      r_dv0          <= 1'b0;
      r_dv1          <= 1'b0;
      r_err          <= 1'b0;
      r_last_owner   <= 1'b1;
    end else begin
      r_ram_rx_valid <= w_hs;
      if (w_hs) r_ram_din <= w_word;
      r_dv0 <= w_rd_ret && !r_owner;
      r_dv1 <= w_rd_ret &&  r_owner;
      if (w_rd_ret && !r_owner) r_dout0 <= bus.ram_dout;
      if (w_rd_ret &&  r_owner) r_dout1 <= bus.ram_dout;
      r_err <= w_err;
      if (w_release) r_last_owner <= r_owner;
    end
  end

  assign bus.req0_ready      = (r_state == S_OWN) && !r_owner;
  assign bus.req1_ready      = (r_state == S_OWN) &&  r_owner;
  assign bus.req0_dout       = r_dout0;
  assign bus.req1_dout       = r_dout1;
  assign bus.req0_dout_valid = r_dv0;
  assign bus.req1_dout_valid = r_dv1;
  assign bus.ram_din         = r_ram_din;
  assign bus.ram_rx_valid    = r_ram_rx_valid;
  assign bus.grant           = r_owner;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.err             = r_err;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: write pair, read return, contention,
// lock timeout, read timeout, stray RAM data and reset during a read.
module tb_spi_ram_arbiter;

  localparam int unsigned TO = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  spi_ram_arbiter_if bus_if ();

  spi_ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_if.req0_din     = '0;
    bus_if.req0_valid   = 1'b0;
    bus_if.req1_din     = '0;
    bus_if.req1_valid   = 1'b0;
    bus_if.ram_dout     = '0;
    bus_if.ram_tx_valid = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_ready0", 32'(bus_if.req0_ready), 0);
    chk("rst_ready1", 32'(bus_if.req1_ready), 0);
    chk("rst_rx_valid", 32'(bus_if.ram_rx_valid), 0);
    chk("rst_ram_din", 32'(bus_if.ram_din), 0);
    chk("rst_grant", 32'(bus_if.grant), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_err", 32'(bus_if.err), 0);
    chk("rst_dout0", 32'(bus_if.req0_dout), 0);
    rst_n = 1'b1;
    tick();

    // Write pair from req0 alone
    bus_if.req0_valid = 1'b1;
    bus_if.req0_din   = 10'h0A5;
    tick();
    chk("wp_ready0", 32'(bus_if.req0_ready), 1);
    chk("wp_ready1", 32'(bus_if.req1_ready), 0);
    chk("wp_busy", 32'(bus_if.busy), 1);
    chk("wp_rx0_pre", 32'(bus_if.ram_rx_valid), 0);
    tick();
    chk("wp_rx1", 32'(bus_if.ram_rx_valid), 1);
    chk("wp_din1", 32'(bus_if.ram_din), 32'h0A5);
    chk("wp_ready0_b2b", 32'(bus_if.req0_ready), 1);
    bus_if.req0_din = 10'h13C;
    tick();
    chk("wp_rx2", 32'(bus_if.ram_rx_valid), 1);
    chk("wp_din2", 32'(bus_if.ram_din), 32'h13C);
    chk("wp_busy_end", 32'(bus_if.busy), 0);
    chk("wp_grant", 32'(bus_if.grant), 0);
    bus_if.req0_valid = 1'b0;
    tick();
    chk("wp_rx_off", 32'(bus_if.ram_rx_valid), 0);

    // Read from req1
    bus_if.req1_valid = 1'b1;
    bus_if.req1_din   = 10'h2A5;
    tick();
    chk("rd_grant", 32'(bus_if.grant), 1);
    chk("rd_ready1", 32'(bus_if.req1_ready), 1);
    chk("rd_ready0", 32'(bus_if.req0_ready), 0);
    tick();
    chk("rd_din_addr", 32'(bus_if.ram_din), 32'h2A5);
    bus_if.req1_din = 10'h300;
    tick();
    chk("rd_din_data", 32'(bus_if.ram_din), 32'h300);
    chk("rd_rx", 32'(bus_if.ram_rx_valid), 1);
    chk("rd_wait_ready1", 32'(bus_if.req1_ready), 0);
    chk("rd_wait_busy", 32'(bus_if.busy), 1);
    bus_if.req1_valid   = 1'b0;
    bus_if.ram_tx_valid = 1'b1;
    bus_if.ram_dout     = 8'h5C;
    tick();
    chk("rd_dv1", 32'(bus_if.req1_dout_valid), 1);
    chk("rd_dout1", 32'(bus_if.req1_dout), 32'h5C);
    chk("rd_dv0", 32'(bus_if.req0_dout_valid), 0);
    chk("rd_busy_end", 32'(bus_if.busy), 0);
    bus_if.ram_tx_valid = 1'b0;
    tick();
    chk("rd_dv1_pulse", 32'(bus_if.req1_dout_valid), 0);

    // Contention from reset: req0 first, req1 held
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_din   = 10'h011;
    bus_if.req1_valid = 1'b1;
    bus_if.req1_din   = 10'h022;
    tick();
    chk("ct_grant0", 32'(bus_if.grant), 0);
    chk("ct_ready0", 32'(bus_if.req0_ready), 1);
    chk("ct_ready1_hold", 32'(bus_if.req1_ready), 0);
    tick();
    bus_if.req0_din = 10'h155;
    chk("ct_ready1_hold2", 32'(bus_if.req1_ready), 0);
    tick();
    chk("ct_din_r0", 32'(bus_if.ram_din), 32'h155);
    chk("ct_idle", 32'(bus_if.busy), 0);
    bus_if.req0_valid = 1'b0;
    tick();
    chk("ct_grant1", 32'(bus_if.grant), 1);
    chk("ct_ready1", 32'(bus_if.req1_ready), 1);
    tick();
    chk("ct_din_r1a", 32'(bus_if.ram_din), 32'h022);
    bus_if.req1_din = 10'h1AA;
    tick();
    chk("ct_din_r1b", 32'(bus_if.ram_din), 32'h1AA);
    // Second contention: last owner was req1, so req0 wins
    bus_if.req1_din   = 10'h044;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_din   = 10'h0A5;
    tick();
    chk("ct2_grant0", 32'(bus_if.grant), 0);
    chk("ct2_ready1_hold", 32'(bus_if.req1_ready), 0);

    // Lock timeout: req0 sends an address then goes quiet, req1 waiting
    tick();
    chk("to_din", 32'(bus_if.ram_din), 32'h0A5);
    bus_if.req0_valid = 1'b0;
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      chk("to_err_early", 32'(bus_if.err), 0);
    end
    chk("to_busy_early", 32'(bus_if.busy), 1);
    tick();
    chk("to_err", 32'(bus_if.err), 1);
    chk("to_idle", 32'(bus_if.busy), 0);
    tick();
    chk("to_err_pulse", 32'(bus_if.err), 0);
    chk("to_grant1", 32'(bus_if.grant), 1);
    chk("to_ready1", 32'(bus_if.req1_ready), 1);

    // Read timeout: req1 issues read data, RAM never answers
    bus_if.req1_din = 10'h300;
    tick();
    chk("rto_wait", 32'(bus_if.busy), 1);
    bus_if.req1_valid = 1'b0;
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      chk("rto_err_early", 32'(bus_if.err), 0);
    end
    tick();
    chk("rto_err", 32'(bus_if.err), 1);
    chk("rto_dv1", 32'(bus_if.req1_dout_valid), 0);
    chk("rto_idle", 32'(bus_if.busy), 0);

    // Stray RAM data in IDLE
    bus_if.ram_tx_valid = 1'b1;
    bus_if.ram_dout     = 8'h77;
    tick();
    chk("stray_dv0", 32'(bus_if.req0_dout_valid), 0);
    chk("stray_dv1", 32'(bus_if.req1_dout_valid), 0);
    chk("stray_dout1", 32'(bus_if.req1_dout), 0);
    bus_if.ram_tx_valid = 1'b0;

    // Reset during WAIT_RD
    bus_if.req0_valid = 1'b1;
    bus_if.req0_din   = 10'h300;
    tick();
    chk("rw_grant0", 32'(bus_if.grant), 0);
    tick();
    bus_if.req0_valid = 1'b0;
    chk("rw_busy", 32'(bus_if.busy), 1);
    chk("rw_rx", 32'(bus_if.ram_rx_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_busy_rst", 32'(bus_if.busy), 0);
    chk("rw_rx_rst", 32'(bus_if.ram_rx_valid), 0);
    chk("rw_din_rst", 32'(bus_if.ram_din), 0);
    chk("rw_ready0_rst", 32'(bus_if.req0_ready), 0);
    bus_if.ram_tx_valid = 1'b1;
    bus_if.ram_dout     = 8'h99;
    tick();
    chk("rw_dv0_inrst", 32'(bus_if.req0_dout_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("rw_dv0_after", 32'(bus_if.req0_dout_valid), 0);
    chk("rw_dout0_after", 32'(bus_if.req0_dout), 0);
    chk("rw_busy_after", 32'(bus_if.busy), 0);
    bus_if.ram_tx_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-port arbiter sharing the single-ported SPI RAM between the SPI slave command stream and a second local requester (e.g. a debug/host port). Each requester issues the RAM's native 10-bit command words; the arbiter serialises them onto the RAM's din/rx_valid input and routes read data (dout/tx_valid) back to the requester that issued the read. Grants are round-robin and locked across an address/data pair, so one requester's latched address is never corrupted by the other.

## Interface
- TIMEOUT, 16: max idle cycles while locked, or while waiting for read data, before forced release (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_din  in  10  requester 0 command word: [9:8] opcode, [7:0] payload
- req0_valid  in  1  requester 0 word valid
- req0_ready  out  1  requester 0 word accepted when valid&ready
- req0_dout  out  8  read data to requester 0
- req0_dout_valid  out  1  one-cycle pulse, req0_dout valid
- req1_din, req1_valid, req1_ready, req1_dout, req1_dout_valid: same as requester 0
- ram_din  out  10  command word to RAM
- ram_rx_valid  out  1  one-cycle strobe, ram_din valid
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read data valid
- grant  out  1  current/last owner index
- busy  out  1  high outside IDLE
- err  out  1  one-cycle pulse on timeout release

## Operation
- Opcodes: 00 write address, 01 write data, 10 read address, 11 read data (RAM answers with ram_tx_valid).
- States: IDLE, OWN, WAIT_RD.
- IDLE: if exactly one req_valid, grant that requester; if both, grant the one not equal to last_owner. Go to OWN. No word is accepted in IDLE.
- OWN: reqN_ready = 1 only for the owner; other requester's ready = 0. On handshake, ram_din <= word, ram_rx_valid <= 1 next cycle.
  - opcode 00 or 10: stay in OWN (lock held).
  - opcode 01: transaction complete -> IDLE, last_owner <= owner.
  - opcode 11: -> WAIT_RD.
- WAIT_RD: ready = 0 for both. On ram_tx_valid: owner's dout <= ram_dout, owner's dout_valid <= 1 next cycle; -> IDLE, last_owner <= owner.
- Timeout counter: cleared on entering OWN/WAIT_RD and on every handshake; increments each cycle otherwise. Reaching TIMEOUT in OWN or WAIT_RD: err pulse, -> IDLE, last_owner <= owner, no dout_valid.
- ram_tx_valid outside WAIT_RD is ignored (no dout_valid to anyone).
- Non-owner's pending valid is held off, never dropped; it wins next IDLE arbitration.

## Timing
- Reset values: state IDLE, all ready/valid/err outputs 0, ram_din 0, req*_dout 0, grant 0, last_owner 1 (requester 0 wins first tie), counter 0.
- Grant latency: valid seen in IDLE at cycle t -> ready high at t+1.
- Command latency: handshake at cycle t -> ram_rx_valid high at t+1 for exactly one cycle.
- Read return: ram_tx_valid at cycle t -> reqN_dout_valid at t+1, state IDLE at t+1; new grant earliest t+2.
- Back-to-back words from owner accepted every cycle while in OWN.
- Reset asserted mid-transaction: immediate return to reset values; no partial strobe completes.

## Test plan
- Write pair from req0 (0x0A5, 0x13C) alone -> ram_rx_valid pulses carry 0x0A5 then 0x13C on consecutive cycles, state returns IDLE, grant=0.
- Read from req1: 0x2A5 then 0x300, RAM returns 0x5C one cycle later -> req1_dout=0x5C with one-cycle req1_dout_valid, req0_dout_valid stays 0.
- Both valid from reset with write pairs -> req0 served first, req1 held (ready=0) until req0's 01 word, then req1 served; second contention goes to req0 again only after req1.
- req0 sends 0x0A5 then drops valid for TIMEOUT cycles -> err pulses once, state IDLE, waiting req1 granted next cycle.
- Read data word issued, ram_tx_valid never asserted -> err after TIMEOUT cycles, no dout_valid; stray ram_tx_valid in IDLE produces no dout_valid.
- rst_n low during WAIT_RD -> all outputs 0 asynchronously, state IDLE, subsequent ram_tx_valid ignored.
